// File: rtl/phy_rst_seq.sv
// PHY reset sequencer: waits for both MMCM locks to be stable, pulses the PHY
// hardware reset, lets the PHY settle, then releases the RGMII datapath.
module phy_rst_seq #(
    parameter int LOCK_FILT_CYCLES = 1000,
    parameter int RST_HOLD_CYCLES  = 1000000,
    parameter int SETTLE_CYCLES    = 5000000
) (
    input  logic       clkIn,
    input  logic       rstIn,
    input  logic       mmcm0LockedIn,
    input  logic       mmcm1LockedIn,
    input  logic       intBIn,
    input  logic       restartIn,
    output logic       phyRstBOut,
    output logic       dpRstOut,
    output logic       readyOut,
    output logic [1:0] stateOut,
    output logic [7:0] lockLossCntOut,
    output logic       intPendOut
);

    localparam int MAX_AB     = (LOCK_FILT_CYCLES > RST_HOLD_CYCLES) ? LOCK_FILT_CYCLES : RST_HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] FILT_LD   = CNT_W'(LOCK_FILT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(RST_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        PHY_RST   = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Bit order: {intB, mmcm1 lock, mmcm0 lock}
    logic [2:0] async_in;
    logic [2:0] sync_vec;

    assign async_in = {intBIn, mmcm1LockedIn, mmcm0LockedIn};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clkIn or posedge rstIn) begin
                if (rstIn) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    logic lock_ok;
    logic int_b_sync;

    assign lock_ok    = sync_vec[0] & sync_vec[1];
    assign int_b_sync = sync_vec[2];

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       loss_reg, loss_next;
    logic             phy_rst_b_reg, phy_rst_b_next;
    logic             dp_rst_reg, dp_rst_next;
    logic             ready_reg, ready_next;
    logic             int_pend_reg, int_pend_next;
    logic             cnt_done;

    assign cnt_done = (cnt_reg == ONE);

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state_reg     <= WAIT_LOCK;
            cnt_reg       <= FILT_LD;
            loss_reg      <= 8'd0;
            phy_rst_b_reg <= 1'b0;
            dp_rst_reg    <= 1'b1;
            ready_reg     <= 1'b0;
            int_pend_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            loss_reg      <= loss_next;
            phy_rst_b_reg <= phy_rst_b_next;
            dp_rst_reg    <= dp_rst_next;
            ready_reg     <= ready_next;
            int_pend_reg  <= int_pend_next;
        end
    end

    // Lock loss is checked first in every state so it always beats restart.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        loss_next  = loss_reg;

        case (state_reg)
            WAIT_LOCK: begin
                if (!lock_ok) begin
                    cnt_next = FILT_LD;
                end else if (cnt_done) begin
                    state_next = PHY_RST;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end
            PHY_RST: begin
                if (!lock_ok) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = FILT_LD;
                end else if (cnt_done) begin
                    state_next = SETTLE;
                    cnt_next   = SETTLE_LD;
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end
            SETTLE: begin
                if (!lock_ok) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = FILT_LD;
                end else if (restartIn) begin
                    state_next = PHY_RST;
                    cnt_next   = HOLD_LD;
                end else if (cnt_done) begin
                    state_next = RUN;
                    cnt_next   = FILT_LD;
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end
            RUN: begin
                if (!lock_ok) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = FILT_LD;
                    loss_next  = (loss_reg == 8'hFF) ? loss_reg : loss_reg + 8'd1;
                end else if (restartIn) begin
                    state_next = PHY_RST;
                    cnt_next   = HOLD_LD;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = FILT_LD;
            end
        endcase
    end

    // Outputs decoded from next-state so they move together with stateOut.
    always_comb begin
        phy_rst_b_next = (state_next == SETTLE) || (state_next == RUN);
        dp_rst_next    = (state_next != RUN);
        ready_next     = (state_next == RUN);
        int_pend_next  = (state_next == RUN) && !int_b_sync;
    end

    assign phyRstBOut     = phy_rst_b_reg;
    assign dpRstOut       = dp_rst_reg;
    assign readyOut       = ready_reg;
    assign stateOut       = state_reg;
    assign lockLossCntOut = loss_reg;
    assign intPendOut     = int_pend_reg;

endmodule

// File: tb/tb_phy_rst_seq.sv
// Bench for phy_rst_seq: directed bring-up scenarios plus randomized lock,
// restart and interrupt traffic compared against a time-in-state reference model.
module tb_phy_rst_seq;

    localparam int LF = 4;
    localparam int RH = 8;
    localparam int ST = 6;
    localparam logic [13:0] RESET_VEC = 14'h0400;

    logic       clk;
    logic       rst;
    logic       m0;
    logic       m1;
    logic       intb;
    logic       restart;
    logic       phy_rst_b;
    logic       dp_rst;
    logic       ready;
    logic [1:0] state;
    logic [7:0] loss_cnt;
    logic       int_pend;
    logic [13:0] dut_vec;

    int tests = 0;
    int fails = 0;

    phy_rst_seq #(
        .LOCK_FILT_CYCLES(LF),
        .RST_HOLD_CYCLES (RH),
        .SETTLE_CYCLES   (ST)
    ) dut (
        .clkIn         (clk),
        .rstIn         (rst),
        .mmcm0LockedIn (m0),
        .mmcm1LockedIn (m1),
        .intBIn        (intb),
        .restartIn     (restart),
        .phyRstBOut    (phy_rst_b),
        .dpRstOut      (dp_rst),
        .readyOut      (ready),
        .stateOut      (state),
        .lockLossCntOut(loss_cnt),
        .intPendOut    (int_pend)
    );

    assign dut_vec = {state, phy_rst_b, dp_rst, ready, int_pend, loss_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state plus elapsed time / run length, inputs delayed two edges.
    int         m_state;
    int         m_run;
    int         m_t;
    int         m_cnt;
    bit         m_intpend;
    logic [2:0] m_q[$];

    task automatic model_reset();
        m_state   = 0;
        m_run     = 0;
        m_t       = 0;
        m_cnt     = 0;
        m_intpend = 0;
        m_q.delete();
        m_q.push_back(3'b000);
        m_q.push_back(3'b000);
    endtask

    task automatic model_edge(input logic a, input logic b, input logic ib, input logic rs);
        logic [2:0] seen;
        bit ok;
        seen = m_q.pop_front();
        m_q.push_back({ib, b, a});
        ok = (seen[0] === 1'b1) && (seen[1] === 1'b1);
        case (m_state)
            0: begin
                if (ok) begin
                    m_run++;
                    if (m_run == LF) begin m_state = 1; m_t = 0; end
                end else m_run = 0;
            end
            1: begin
                if (!ok) begin m_state = 0; m_run = 0; end
                else begin
                    m_t++;
                    if (m_t == RH) begin m_state = 2; m_t = 0; end
                end
            end
            2: begin
                if (!ok) begin m_state = 0; m_run = 0; end
                else if (rs) begin m_state = 1; m_t = 0; end
                else begin
                    m_t++;
                    if (m_t == ST) m_state = 3;
                end
            end
            default: begin
                if (!ok) begin
                    m_state = 0;
                    m_run = 0;
                    if (m_cnt < 255) m_cnt++;
                end else if (rs) begin
                    m_state = 1;
                    m_t = 0;
                end
            end
        endcase
        m_intpend = (m_state == 3) && (seen[2] === 1'b0);
    endtask

    function automatic logic [13:0] model_vec();
        logic [13:0] v;
        v = {2'(m_state), (m_state >= 2) ? 1'b1 : 1'b0, (m_state != 3) ? 1'b1 : 1'b0,
             (m_state == 3) ? 1'b1 : 1'b0, m_intpend ? 1'b1 : 1'b0, 8'(m_cnt)};
        return v;
    endfunction

    // Drive one cycle of inputs (from a negedge), advance model at posedge, return at negedge.
    task automatic step(input logic a, input logic b, input logic ib, input logic rs);
        m0 = a; m1 = b; intb = ib; restart = rs;
        @(posedge clk);
        model_edge(a, b, ib, rs);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0 = 1'b0; m1 = 1'b0; intb = 1'b1; restart = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bring_to_run(input logic ib);
        int n;
        n = 0;
        while (state !== 2'd3 && n < 100) begin
            step(1'b1, 1'b1, ib, 1'b0);
            n++;
        end
        tests++;
        if (state !== 2'd3) begin
            fails++;
            $display("FAIL bring_to_run timeout: state=%0d required 3 within 100 cycles", state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0 = 1'b1; m1 = 1'b1; intb = 1'b0; restart = 1'b1;
        model_reset();
        #1;
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++;
            $display("FAIL reset_async: got %h required %h", dut_vec, RESET_VEC);
        end
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++;
            $display("FAIL reset_held: got %h required %h", dut_vec, RESET_VEC);
        end
        rst = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_bringup();
        int first_phy, rst_low, first_rise, first_ready;
        first_phy = -1; rst_low = 0; first_rise = -1; first_ready = -1;
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            tests++;
            if (dut_vec !== model_vec()) begin
                fails++;
                $display("FAIL bringup_cycle%0d: got %h required %h", k, dut_vec, model_vec());
            end
            if (state === 2'd1 && first_phy < 0) first_phy = k;
            if (state === 2'd1 && phy_rst_b === 1'b0) rst_low++;
            if (phy_rst_b === 1'b1 && first_rise < 0) first_rise = k;
            if (ready === 1'b1 && first_ready < 0) first_ready = k;
        end
        tests++;
        if (first_phy !== 6) begin
            fails++;
            $display("FAIL bringup_phy_rst_entry: cycle %0d required 6", first_phy);
        end
        tests++;
        if (rst_low !== RH) begin
            fails++;
            $display("FAIL bringup_rst_hold: %0d cycles required %0d", rst_low, RH);
        end
        tests++;
        if (first_ready - first_rise !== ST || first_rise < 0) begin
            fails++;
            $display("FAIL bringup_settle: ready-rise=%0d required %0d", first_ready - first_rise, ST);
        end
        $display("[TB] test_bringup done: phy_rst at %0d, release at %0d, ready at %0d",
                 first_phy, first_rise, first_ready);
    endtask

    task automatic test_filter_glitch();
        int first_phy;
        first_phy = -1;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, (k == 4) ? 1'b0 : 1'b1, 1'b1, 1'b0);
            tests++;
            if (dut_vec !== model_vec()) begin
                fails++;
                $display("FAIL glitch_cycle%0d: got %h required %h", k, dut_vec, model_vec());
            end
            if (state === 2'd1 && first_phy < 0) first_phy = k;
        end
        tests++;
        if (first_phy !== 10) begin
            fails++;
            $display("FAIL glitch_phy_rst_entry: cycle %0d required 10", first_phy);
        end
        $display("[TB] test_filter_glitch done: phy_rst at %0d", first_phy);
    endtask

    task automatic test_lock_loss_run();
        do_reset();
        bring_to_run(1'b1);
        tests++;
        if (loss_cnt !== 8'd0) begin
            fails++;
            $display("FAIL lockloss_before: count %0d required 0", loss_cnt);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        tests++;
        if ({state, ready, dp_rst, phy_rst_b, loss_cnt} !== {2'd0, 1'b0, 1'b1, 1'b0, 8'd1}) begin
            fails++;
            $display("FAIL lockloss_after: state=%0d ready=%b dp=%b phyb=%b cnt=%0d required 0 0 1 0 1",
                     state, ready, dp_rst, phy_rst_b, loss_cnt);
        end
        tests++;
        if (dut_vec !== model_vec()) begin
            fails++;
            $display("FAIL lockloss_model: got %h required %h", dut_vec, model_vec());
        end
        $display("[TB] test_lock_loss_run done: count=%0d", loss_cnt);
    endtask

    task automatic test_restart();
        do_reset();
        bring_to_run(1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        tests++;
        if ({state, loss_cnt} !== {2'd1, 8'd0}) begin
            fails++;
            $display("FAIL restart_alone: state=%0d cnt=%0d required 1 0", state, loss_cnt);
        end
        bring_to_run(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        tests++;
        if ({state, loss_cnt} !== {2'd0, 8'd1}) begin
            fails++;
            $display("FAIL restart_with_lockloss: state=%0d cnt=%0d required 0 1", state, loss_cnt);
        end
        tests++;
        if (dut_vec !== model_vec()) begin
            fails++;
            $display("FAIL restart_model: got %h required %h", dut_vec, model_vec());
        end
        $display("[TB] test_restart done");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            bring_to_run(1'b1);
            step(1'b0, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1, 1'b0);
            tests++;
            if (dut_vec !== model_vec()) begin
                fails++;
                $display("FAIL saturation_loss%0d: got %h required %h", n, dut_vec, model_vec());
            end
        end
        tests++;
        if (loss_cnt !== 8'd255) begin
            fails++;
            $display("FAIL saturation_final: count %0d required 255", loss_cnt);
        end
        $display("[TB] test_saturation done: count=%0d", loss_cnt);
    endtask

    task automatic test_reset_mid_settle_and_int();
        int n;
        bit seen_settle;
        do_reset();
        n = 0;
        while (state !== 2'd2 && n < 50) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            n++;
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++;
            $display("FAIL reset_mid_settle: got %h required %h", dut_vec, RESET_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (state !== 2'd2 && n < 50) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            n++;
        end
        seen_settle = 0;
        n = 0;
        while (state === 2'd2 && n < 20) begin
            seen_settle = 1;
            tests++;
            if (int_pend !== 1'b0) begin
                fails++;
                $display("FAIL int_in_settle: intPend=%b required 0", int_pend);
            end
            step(1'b1, 1'b1, 1'b0, 1'b0);
            n++;
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({seen_settle, state, int_pend} !== {1'b1, 2'd3, 1'b1}) begin
            fails++;
            $display("FAIL int_in_run: settle_seen=%b state=%0d intPend=%b required 1 3 1",
                     seen_settle, state, int_pend);
        end
        tests++;
        if (dut_vec !== model_vec()) begin
            fails++;
            $display("FAIL int_model: got %h required %h", dut_vec, model_vec());
        end
        $display("[TB] test_reset_mid_settle_and_int done");
    endtask

    task automatic test_random();
        logic a, b, ib, rs;
        int bad;
        bad = 0;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            a  = ($urandom_range(0, 149) != 0);
            b  = ($urandom_range(0, 149) != 0);
            ib = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 39) == 0);
            step(a, b, ib, rs);
            tests++;
            if (dut_vec !== model_vec()) begin
                fails++;
                bad++;
                $display("FAIL random_cycle%0d: got %h required %h", k, dut_vec, model_vec());
            end
        end
        $display("[TB] test_random done: 3000 cycles, final count=%0d, %0d mismatches", loss_cnt, bad);
    endtask

    initial begin
        rst = 1'b1;
        m0 = 1'b0; m1 = 1'b0; intb = 1'b1; restart = 1'b0;
        @(negedge clk);
        test_reset();
        test_bringup();
        test_filter_glitch();
        test_lock_loss_run();
        test_restart();
        test_reset_mid_settle_and_int();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/phy_rst_seq.md
PHY_RST_SEQ -- requirements
Module: phy_rst_seq

Interface
REQ-001 SHALL have parameter LOCK_FILT_CYCLES, default 1000, consecutive cycles both locks must be stable before PHY reset.
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 1000000, cycles phyRstBOut held low (10 ms at 100 MHz).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 5000000, cycles after PHY reset release before datapath enable (50 ms).
REQ-004 SHALL have port clkIn, input, 1, local 100 MHz clock; the single clock.
REQ-005 SHALL have port rstIn, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port mmcm0LockedIn, input, 1, MMCM0 lock; asynchronous to clkIn.
REQ-007 SHALL have port mmcm1LockedIn, input, 1, MMCM1 lock; asynchronous to clkIn.
REQ-008 SHALL have port intBIn, input, 1, PHY interrupt, active-low, asynchronous.
REQ-009 SHALL have port restartIn, input, 1, single-cycle request to re-run the PHY reset.
REQ-010 SHALL have port phyRstBOut, output, 1, PHY hardware reset, active-low.
REQ-011 SHALL have port dpRstOut, output, 1, RGMII TX/RX datapath reset, active-high.
REQ-012 SHALL have port readyOut, output, 1, link bring-up sequence complete.
REQ-013 SHALL have port stateOut, output, 2, current state encoding.
REQ-014 SHALL have port lockLossCntOut, output, 8, count of lock losses seen in RUN.
REQ-015 SHALL have port intPendOut, output, 1, synchronised PHY interrupt, valid in RUN only.

Function
REQ-016 SHALL synchronise mmcm0LockedIn, mmcm1LockedIn and intBIn through two flops each; all logic uses synchronised copies only (2-cycle latency).
REQ-017 SHALL encode states WAIT_LOCK=0, PHY_RST=1, SETTLE=2, RUN=3 on stateOut.
REQ-018 SHALL use a single down-counter, wide enough for the largest parameter, reloaded on every state entry.
REQ-019 WAIT_LOCK: phyRstBOut=0, dpRstOut=1, readyOut=0; filter counts consecutive cycles with both synced locks high; any low sample reloads it; after LOCK_FILT_CYCLES consecutive high samples -> PHY_RST.
REQ-020 PHY_RST: phyRstBOut=0, dpRstOut=1, readyOut=0; exactly RST_HOLD_CYCLES cycles, then -> SETTLE.
REQ-021 SETTLE: phyRstBOut=1, dpRstOut=1, readyOut=0; exactly SETTLE_CYCLES cycles, then -> RUN.
REQ-022 RUN: phyRstBOut=1, dpRstOut=0, readyOut=1; remains until lock loss or restart.
REQ-023 In PHY_RST, SETTLE or RUN, either synced lock low SHALL force -> WAIT_LOCK next cycle.
REQ-024 lockLossCntOut SHALL increment only on a lock-loss exit from RUN, saturating at 255.
REQ-025 restartIn high in SETTLE or RUN SHALL force -> PHY_RST; ignored in WAIT_LOCK and PHY_RST.
REQ-026 Lock loss and restartIn in the same cycle: lock loss wins (-> WAIT_LOCK, count increments if in RUN).
REQ-027 All outputs SHALL be registered and decoded from next-state, so they change in the same cycle as stateOut; no combinational paths from inputs to outputs.
REQ-028 intPendOut SHALL equal the inverted synced intBIn in RUN, 0 otherwise.

Reset
REQ-029 rstIn high SHALL asynchronously force state WAIT_LOCK, phyRstBOut=0, dpRstOut=1, readyOut=0, stateOut=0, lockLossCntOut=0, intPendOut=0, synchronisers=0, counter reloaded with LOCK_FILT_CYCLES.
REQ-030 After rstIn deasserts, the sequence SHALL restart from WAIT_LOCK whatever the lock state; rstIn mid-sequence aborts without completing the current hold.

Verification (LOCK_FILT=4, RST_HOLD=8, SETTLE=6)
REQ-031 Both locks rise at cycle 0 after reset -> stateOut=1 at cycle 6; phyRstBOut low exactly 8 cycles; readyOut=1 exactly 6 cycles after phyRstBOut rises.
REQ-032 mmcm1LockedIn low for 1 cycle during the filter window -> filter reloads; PHY_RST entry delayed by the full 4 cycles after the glitch.
REQ-033 Drop mmcm0LockedIn in RUN -> stateOut=0, readyOut=0, dpRstOut=1, phyRstBOut=0 within 3 cycles; lockLossCntOut 0->1.
REQ-034 restartIn pulse and lock drop in the same RUN cycle -> WAIT_LOCK, count increments; restartIn alone in RUN -> PHY_RST, count unchanged.
REQ-035 Force 256 lock losses from RUN -> lockLossCntOut stays 255.
REQ-036 rstIn pulse mid-SETTLE -> outputs return to reset values immediately; intBIn low in SETTLE -> intPendOut=0, then 1 two cycles into RUN.
